// File: rtl/serial_magnitude_comparator.sv
// Unsigned magnitude comparator that scans two captured operands MSB-first,
// one bit per clock, and stops at the first differing bit.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_greater_than_B,
  output logic             A_less_than_B,
  output logic             A_equal_B
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] w_sa_next;
  logic [WIDTH-1:0] w_sb_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;
  logic             w_gt_next;
  logic             w_lt_next;
  logic             w_eq_next;
  logic             w_msb_a;
  logic             w_msb_b;

  assign w_msb_a = r_sa[WIDTH-1];
  assign w_msb_b = r_sb[WIDTH-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sa    <= w_sa_next;
      r_sb    <= w_sb_next;
      r_cnt   <= w_cnt_next;
      r_gt    <= w_gt_next;
      r_lt    <= w_lt_next;
      r_eq    <= w_eq_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sa_next    = r_sa;
    w_sb_next    = r_sb;
    w_cnt_next   = r_cnt;
    w_gt_next    = r_gt;
    w_lt_next    = r_lt;
    w_eq_next    = r_eq;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sa_next    = A;
          w_sb_next    = B;
          w_cnt_next   = CW'(WIDTH);
          w_gt_next    = 1'b0;
          w_lt_next    = 1'b0;
          w_eq_next    = 1'b0;
          w_state_next = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (w_msb_a && !w_msb_b) begin
          w_gt_next    = 1'b1;
          w_state_next = S_DONE;
        end else if (!w_msb_a && w_msb_b) begin
          w_lt_next    = 1'b1;
          w_state_next = S_DONE;
        end else if (r_cnt == CW'(1)) begin
          // Last bit matched too: operands are identical.
          w_eq_next    = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_sa_next  = {r_sa[WIDTH-2:0], 1'b0};
          w_sb_next  = {r_sb[WIDTH-2:0], 1'b0};
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_DONE);
  assign A_greater_than_B = r_gt;
  assign A_less_than_B    = r_lt;
  assign A_equal_B        = r_eq;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: latency/result model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_serial_magnitude_comparator;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic         A_greater_than_B;
  logic         A_less_than_B;
  logic         A_equal_B;

  int errors = 0;
  int checks = 0;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .A(A),
    .B(B),
    .busy(busy),
    .done(done),
    .A_greater_than_B(A_greater_than_B),
    .A_less_than_B(A_less_than_B),
    .A_equal_B(A_equal_B)
  );

  always #5 clock = ~clock;

  // Input sampling at each rising edge feeds the model.
  int           cyc = 0;
  logic         smp_rst = 1'b0;
  logic         smp_start = 1'b0;
  logic [W-1:0] smp_a = '0;
  logic [W-1:0] smp_b = '0;

  always @(posedge clock) begin
    cyc       <= cyc + 1;
    smp_rst   <= reset;
    smp_start <= start;
    smp_a     <= A;
    smp_b     <= B;
  end

  // Decision edge counted from the start edge: first differing bit at
  // position i (from MSB, m = W-1-i equal bits before it) gives m+1.
  function automatic int lat_of(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = W - 1; i >= 0; i--)
      if (a[i] != b[i]) return W - i;
    return W;
  endfunction

  bit           m_valid = 0;
  bit           m_active = 0;
  int           m_t0 = 0;
  int           m_lat = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [2:0]   m_flags = 3'b000;   // {gt, lt, eq}

  always @(negedge clock) begin
    logic [4:0] exp_v;
    logic [4:0] act_v;
    if (smp_rst) begin
      m_valid  = 1;
      m_active = 0;
      m_flags  = 3'b000;
    end else if (m_valid) begin
      if (smp_start && (!m_active || cyc >= m_t0 + m_lat + 2)) begin
        m_active = 1;
        m_t0     = cyc;
        m_a      = smp_a;
        m_b      = smp_b;
        m_lat    = lat_of(smp_a, smp_b);
        m_flags  = 3'b000;
      end
      if (m_active && cyc == m_t0 + m_lat)
        m_flags = {m_a > m_b, m_a < m_b, m_a == m_b};
    end
    if (m_valid) begin
      exp_v = {m_active && cyc <= m_t0 + m_lat, m_active && cyc == m_t0 + m_lat, m_flags};
      act_v = {busy, done, A_greater_than_B, A_less_than_B, A_equal_B};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model cyc=%0d {busy,done,gt,lt,eq} got=%b want=%b", cyc, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Start a comparison and count edges after the start edge until done.
  task automatic go(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                    input bit restart, input int exp_cyc, input logic [2:0] exp_flags);
    int n;
    @(posedge clock); #1;
    A = a; B = b; start = 1'b1;
    @(posedge clock); #1;
    start = restart;
    if (restart) A = 8'hFF;
    check({name, "_clr"}, {A_greater_than_B, A_less_than_B, A_equal_B}, 3'b000);
    n = 0;
    while (n < 20) begin
      @(posedge clock); #1;
      start = 1'b0;
      n++;
      if (done) break;
    end
    check({name, "_lat"}, n, exp_cyc);
    check({name, "_flags"}, {A_greater_than_B, A_less_than_B, A_equal_B}, exp_flags);
    $display("txn %s A=%h B=%h latency=%0d flags=%b", name, a, b, n,
             {A_greater_than_B, A_less_than_B, A_equal_B});
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_outs", {busy, done, A_greater_than_B, A_less_than_B, A_equal_B}, 5'b0);
    repeat (5) @(posedge clock);
    #1 check("idle_outs", {busy, done, A_greater_than_B, A_less_than_B, A_equal_B}, 5'b0);

    go("gt_msb", 8'h80, 8'h7F, 0, 1, 3'b100);
    @(posedge clock); #1;
    check("busy_drop", {busy, done}, 2'b00);

    go("lt_lsb", 8'h5A, 8'h5B, 0, 8, 3'b010);
    repeat (3) @(posedge clock);
    #1 check("hold_lt", {A_greater_than_B, A_less_than_B, A_equal_B}, 3'b010);

    go("eq_c3", 8'hC3, 8'hC3, 0, 8, 3'b001);
    go("lt_0102", 8'h01, 8'h02, 0, 7, 3'b010);
    go("ignore_start", 8'h0F, 8'h0E, 1, 8, 3'b100);

    // Reset in the middle of a comparison.
    @(posedge clock); #1;
    A = 8'h00; B = 8'h00; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_reset", {busy, done, A_greater_than_B, A_less_than_B, A_equal_B}, 5'b0);
    go("lt_feff", 8'hFE, 8'hFF, 0, 8, 3'b010);

    // Random traffic: starts at any time, occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(posedge clock); #1;
      start = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 59) == 0);
      A = W'($urandom);
      case ($urandom_range(0, 3))
        0: B = A;
        1: B = A ^ (W'(1) << $urandom_range(0, W - 1));
        default: B = W'($urandom);
      endcase
    end
    @(posedge clock); #1;
    start = 1'b0; reset = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
